// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared encodings for the hazard-response path. Holds the
//               forwarding-select codes, the ID/EX control FSM state
//               encodings and the default ALU op width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Forwarding select codes; 2'b11 is reserved and treated as FWD_NONE
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int ALUOP_W_DEF = 4;

  // ID/EX control state: what the pipeline register did on the last edge
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fwd_mux_v.sv
// ============================================================================
// Module      : fwd_mux_v
// Description : 3:1 operand forwarding select. Picks the registered operand,
//               the EX/MEM ALU result or the MEM/WB write-back data. The
//               reserved select code falls back to the registered operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux_v
  import hazard_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] reg_i,
  input  logic [XLEN-1:0] exmem_i,
  input  logic [XLEN-1:0] memwb_i,
  output logic [XLEN-1:0] data_o
);

  // Forwarding source select with reserved-code fallback to the register value
  always_comb begin
    data_o = reg_i;
    case (sel_i)
      FWD_EXMEM: data_o = exmem_i;
      FWD_MEMWB: data_o = memwb_i;
      default:   data_o = reg_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idex_pipe_v.sv
// ============================================================================
// Module      : idex_pipe_v
// Description : ID/EX pipeline register with hazard response. Inserts bubbles
//               on load-use stall and taken-branch flush, drives the PC and
//               IF/ID enables, forwards EX operands and runs a stall watchdog.
//               Optional macro IDEX_PERF_CNT_EN enables saturating stall and
//               flush performance counters; otherwise both read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_pipe_v
  import hazard_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_memRead,
  input  logic               id_memWrite,
  input  logic               id_regWrite,
  input  logic               id_aluSrc,
  input  logic [ALUOP_W-1:0] id_aluOp,
  input  logic               stall,
  input  logic               flush,
  input  logic [1:0]         forwA,
  input  logic [1:0]         forwB,
  input  logic [XLEN-1:0]    exmem_alu,
  input  logic [XLEN-1:0]    memwb_wdata,
  output logic               idex_valid,
  output logic [4:0]         idex_rs1,
  output logic [4:0]         idex_rs2,
  output logic [4:0]         idex_rd,
  output logic               idex_memRead,
  output logic               idex_memWrite,
  output logic               idex_regWrite,
  output logic               idex_aluSrc,
  output logic [ALUOP_W-1:0] idex_aluOp,
  output logic [XLEN-1:0]    idex_imm,
  output logic [XLEN-1:0]    ex_opA,
  output logic [XLEN-1:0]    ex_opB,
  output logic [XLEN-1:0]    ex_storeData,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               stall_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int              RUN_W   = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  state_e state_q, state_d;
  logic   bubble;

  logic               valid_q, valid_d;
  logic [4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic               memRead_q, memRead_d, memWrite_q, memWrite_d;
  logic               regWrite_q, regWrite_d, aluSrc_q, aluSrc_d;
  logic [ALUOP_W-1:0] aluOp_q, aluOp_d;
  logic [XLEN-1:0]    imm_q, imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;

  logic [RUN_W-1:0]   run_q, run_d;
  logic               err_q, err_d;

  logic [XLEN-1:0]    fwd_a, fwd_b;

  // Next state by priority flush > stall > run, plus front-end enables
  always_comb begin
    state_d    = ST_RUN;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    if (flush) begin
      state_d    = ST_FLUSH;
      ifid_flush = 1'b1;
    end else if (stall) begin
      state_d = ST_STALL;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end
  end

  assign bubble = (state_d != ST_RUN);

  // ID/EX next value: capture decode, or a bubble that zeroes control and rd
  always_comb begin
    valid_d    = id_valid;
    rs1_d      = id_rs1;
    rs2_d      = id_rs2;
    rd_d       = id_rd;
    memRead_d  = id_memRead;
    memWrite_d = id_memWrite;
    regWrite_d = id_regWrite;
    aluSrc_d   = id_aluSrc;
    aluOp_d    = id_aluOp;
    imm_d      = id_imm;
    rs1_data_d = id_rs1_data;
    rs2_data_d = id_rs2_data;
    if (bubble) begin
      valid_d    = 1'b0;
      rd_d       = '0;
      memRead_d  = 1'b0;
      memWrite_d = 1'b0;
      regWrite_d = 1'b0;
      aluSrc_d   = 1'b0;
      aluOp_d    = '0;
      // Data fields are don't-care in a bubble; holding them avoids toggling
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      imm_d      = imm_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
    end
  end

  // Watchdog: length of the current stall run, sticky error at the limit
  always_comb begin
    run_d = '0;
    err_d = err_q;
    if (state_d == ST_STALL) begin
      if (state_q != ST_STALL) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end else begin
        run_d = run_q;
      end
    end
    if (run_d == RUN_MAX) begin
      err_d = 1'b1;
    end
  end

  // State, ID/EX fields and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      regWrite_q <= 1'b0;
      aluSrc_q   <= 1'b0;
      aluOp_q    <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      run_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      regWrite_q <= regWrite_d;
      aluSrc_q   <= aluSrc_d;
      aluOp_q    <= aluOp_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  fwd_mux_v #(.XLEN(XLEN)) u_fwd_a (
    .sel_i   (forwA),
    .reg_i   (rs1_data_q),
    .exmem_i (exmem_alu),
    .memwb_i (memwb_wdata),
    .data_o  (fwd_a)
  );

  fwd_mux_v #(.XLEN(XLEN)) u_fwd_b (
    .sel_i   (forwB),
    .reg_i   (rs2_data_q),
    .exmem_i (exmem_alu),
    .memwb_i (memwb_wdata),
    .data_o  (fwd_b)
  );

  assign ex_opA       = fwd_a;
  assign ex_opB       = aluSrc_q ? imm_q : fwd_b;
  assign ex_storeData = fwd_b;

  assign idex_valid    = valid_q;
  assign idex_rs1      = rs1_q;
  assign idex_rs2      = rs2_q;
  assign idex_rd       = rd_q;
  assign idex_memRead  = memRead_q;
  assign idex_memWrite = memWrite_q;
  assign idex_regWrite = regWrite_q;
  assign idex_aluSrc   = aluSrc_q;
  assign idex_aluOp    = aluOp_q;
  assign idex_imm      = imm_q;
  assign stall_err     = err_q;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;

  // Saturating counters: stall-only cycles and flush cycles
  always_comb begin
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (flush) begin
      if (fcnt_q != {CNT_W{1'b1}}) fcnt_d = fcnt_q + 1'b1;
    end else if (stall) begin
      if (scnt_q != {CNT_W{1'b1}}) scnt_d = scnt_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign stall_cnt = scnt_q;
  assign flush_cnt = fcnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_idex_pipe_v.sv
// ============================================================================
// Module      : tb_idex_pipe_v
// Description : Self-checking bench for idex_pipe_v. A behavioural model of
//               the ID/EX register, watchdog and counters is checked against
//               the DUT every cycle, alongside directed literal expectations.
//               Honours IDEX_PERF_CNT_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idex_pipe_v;

  localparam int XLEN = 32;
  localparam int MAXS = 8;
`ifdef IDEX_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_memRead, id_memWrite, id_regWrite, id_aluSrc, stall, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, exmem_alu, memwb_wdata;
  logic [3:0] id_aluOp;
  logic [1:0] forwA, forwB;

  logic idex_valid, idex_memRead, idex_memWrite, idex_regWrite, idex_aluSrc;
  logic [4:0] idex_rs1, idex_rs2, idex_rd;
  logic [3:0] idex_aluOp;
  logic [XLEN-1:0] idex_imm, ex_opA, ex_opB, ex_storeData;
  logic pc_we, ifid_we, ifid_flush, stall_err;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  idex_pipe_v #(.XLEN(XLEN), .ALUOP_W(4), .MAX_STALL(MAXS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_regWrite(id_regWrite),
    .id_aluSrc(id_aluSrc), .id_aluOp(id_aluOp), .stall(stall), .flush(flush),
    .forwA(forwA), .forwB(forwB), .exmem_alu(exmem_alu), .memwb_wdata(memwb_wdata),
    .idex_valid(idex_valid), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memRead(idex_memRead), .idex_memWrite(idex_memWrite),
    .idex_regWrite(idex_regWrite), .idex_aluSrc(idex_aluSrc), .idex_aluOp(idex_aluOp),
    .idex_imm(idex_imm), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_storeData(ex_storeData),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .stall_err(stall_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 0, m_mr = 0, m_mw = 0, m_rw = 0, m_as = 0, m_err = 0;
  logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0;
  logic [3:0]  m_op = 0;
  logic [31:0] m_imm = 0, m_d1 = 0, m_d2 = 0;
  int          m_run = 0, m_scnt = 0, m_fcnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_mr <= 0; m_mw <= 0; m_rw <= 0; m_as <= 0; m_err <= 0;
      m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_op <= 0; m_imm <= 0; m_d1 <= 0; m_d2 <= 0;
      m_run <= 0; m_scnt <= 0; m_fcnt <= 0;
    end else begin
      if (flush || stall) begin
        m_valid <= 0; m_mr <= 0; m_mw <= 0; m_rw <= 0; m_rd <= 0;
      end else begin
        m_valid <= id_valid; m_mr <= id_memRead; m_mw <= id_memWrite; m_rw <= id_regWrite;
        m_as <= id_aluSrc; m_op <= id_aluOp; m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
        m_imm <= id_imm; m_d1 <= id_rs1_data; m_d2 <= id_rs2_data;
      end
      if (stall && !flush) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= MAXS) m_err <= 1;
      end else begin
        m_run <= 0;
      end
      if (PERF != 0) begin
        if (flush) m_fcnt <= (m_fcnt == 65535) ? m_fcnt : m_fcnt + 1;
        else if (stall) m_scnt <= (m_scnt == 65535) ? m_scnt : m_scnt + 1;
      end
    end
  end

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'b01) return exmem_alu;
    if (s == 2'b10) return memwb_wdata;
    return r;
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("m_pc_we", pc_we, (stall && !flush) ? 1'b0 : 1'b1);
    chk("m_ifid_we", ifid_we, (stall && !flush) ? 1'b0 : 1'b1);
    chk("m_ifid_flush", ifid_flush, flush);
    chk("m_valid", idex_valid, m_valid);
    chk("m_rd", idex_rd, m_rd);
    chk("m_memRead", idex_memRead, m_mr);
    chk("m_memWrite", idex_memWrite, m_mw);
    chk("m_regWrite", idex_regWrite, m_rw);
    chk("m_stall_err", stall_err, m_err);
    chk("m_stall_cnt", stall_cnt, 64'(m_scnt));
    chk("m_flush_cnt", flush_cnt, 64'(m_fcnt));
    if (m_valid) begin
      chk("m_rs1", idex_rs1, m_rs1);
      chk("m_rs2", idex_rs2, m_rs2);
      chk("m_aluSrc", idex_aluSrc, m_as);
      chk("m_aluOp", idex_aluOp, m_op);
      chk("m_imm", idex_imm, m_imm);
      chk("m_opA", ex_opA, pick(forwA, m_d1));
      chk("m_opB", ex_opB, m_as ? m_imm : pick(forwB, m_d2));
      chk("m_store", ex_storeData, pick(forwB, m_d2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 5'd7; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_memRead = 0; id_memWrite = 0; id_regWrite = 1; id_aluSrc = 0;
    id_aluOp = 4'h3; stall = 0; flush = 0; forwA = 0; forwB = 0; exmem_alu = 0; memwb_wdata = 0;

    // Reset state
    mid();
    chk("rst_valid", idex_valid, 0);
    chk("rst_rd", idex_rd, 0);
    chk("rst_err", stall_err, 0);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);

    // Release reset; normal capture
    cyc();
    rst_n = 1;
    id_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_data = 32'h10; id_rs2_data = 32'h20;
    id_imm = 32'h4;
    mid();
    chk("rel_pc_we", pc_we, 1);
    cyc();
    mid();
    chk("cap_rd", idex_rd, 5);
    chk("cap_valid", idex_valid, 1);
    chk("cap_opA", ex_opA, 32'h10);
    chk("cap_opB", ex_opB, 32'h20);

    // Asynchronous reset mid-cycle clears ID/EX immediately
    #2 rst_n = 0;
    #1;
    chk("arst_valid", idex_valid, 0);
    chk("arst_rd", idex_rd, 0);
    chk("arst_regWrite", idex_regWrite, 0);
    cyc();
    rst_n = 1;

    // Immediate on opB, forwarded rs2 on storeData
    id_aluSrc = 1; id_imm = 32'h100; id_rs2_data = 32'h33; forwB = 2'b10; memwb_wdata = 32'h55;
    cyc();
    mid();
    chk("imm_opB", ex_opB, 32'h100);
    chk("imm_store", ex_storeData, 32'h55);

    // Load-use stall for one cycle
    cyc();
    id_aluSrc = 0; forwB = 0; stall = 1; id_rd = 5'd9;
    mid();
    chk("stl_pc_we", pc_we, 0);
    chk("stl_ifid_we", ifid_we, 0);
    cyc();
    stall = 0;
    mid();
    chk("stl_valid", idex_valid, 0);
    chk("stl_regWrite", idex_regWrite, 0);
    chk("stl_rd", idex_rd, 0);
    chk("stl_scnt", stall_cnt, 64'(PERF));

    // Stall and flush together: flush wins
    cyc();
    stall = 1; flush = 1;
    mid();
    chk("sf_pc_we", pc_we, 1);
    chk("sf_ifid_flush", ifid_flush, 1);
    chk("sf_ifid_we", ifid_we, 1);
    cyc();
    stall = 0; flush = 0; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    mid();
    chk("sf_valid", idex_valid, 0);
    chk("sf_rd", idex_rd, 0);
    chk("sf_fcnt", flush_cnt, 64'(PERF));
    chk("sf_scnt", stall_cnt, 64'(PERF));

    // Forwarding paths, then reserved code falls back to register data
    cyc();
    forwA = 2'b01; exmem_alu = 32'hAA; forwB = 2'b10; memwb_wdata = 32'h55;
    mid();
    chk("fw_opA", ex_opA, 32'hAA);
    chk("fw_opB", ex_opB, 32'h55);
    chk("fw_store", ex_storeData, 32'h55);
    cyc();
    forwA = 2'b11; forwB = 2'b11;
    mid();
    chk("fw11_opA", ex_opA, 32'h11);
    chk("fw11_opB", ex_opB, 32'h22);
    cyc();
    forwA = 0; forwB = 0;

    // Watchdog: seven stall cycles do not trip it
    stall = 1;
    repeat (7) cyc();
    stall = 0;
    mid();
    chk("wd7_err", stall_err, 0);

    // A flush inside a stall run restarts the count
    cyc();
    stall = 1;
    repeat (5) cyc();
    flush = 1;
    cyc();
    flush = 0;
    repeat (5) cyc();
    stall = 0;
    mid();
    chk("wdfl_err", stall_err, 0);

    // Eight consecutive stall cycles set the sticky error
    cyc();
    stall = 1;
    repeat (7) cyc();
    mid();
    chk("wd7b_err", stall_err, 0);
    cyc();
    stall = 0;
    mid();
    chk("wd8_err", stall_err, 1);
    cyc();
    cyc();
    mid();
    chk("wd_sticky", stall_err, 1);

    // Reset asserted mid-stall clears the watchdog and leaves a bubble
    cyc();
    stall = 1;
    cyc();
    cyc();
    mid();
    #2 rst_n = 0;
    #1;
    chk("rs_err", stall_err, 0);
    chk("rs_valid", idex_valid, 0);
    cyc();
    stall = 0; rst_n = 1;
    mid();
    chk("rs_pc_we", pc_we, 1);
    cyc();
    mid();
    chk("rs_cap_valid", idex_valid, 1);
    chk("rs_cap_rd", idex_rd, 9);

    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
